// File: rtl/vs_pkg.sv
// Shared types and width helpers for the video stream switch.
package vs_pkg;

  typedef enum logic {RUN = 1'b0, WAIT = 1'b1} state_e;

  // Number of sideband bits carried next to each pixel (de, h_sync, v_sync).
  localparam int VS_SIDEBAND_W = 3;

  function automatic int cnt_width(input int timeout);
    return ($clog2(timeout) < 1) ? 1 : $clog2(timeout);
  endfunction

  function automatic int pix_lsb(input int ch, input int pix_w);
    return ch * pix_w;
  endfunction

endpackage

// File: rtl/vstream_mux_reg.sv
// N_CH:1 stream mux feeding one output register stage.
module vstream_mux_reg
  import vs_pkg::*;
#(
  parameter int N_CH  = 16,
  parameter int PIX_W = 24,
  parameter int SEL_W = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [SEL_W-1:0]      idx,
  input  logic [N_CH*PIX_W-1:0] pixel_in,
  input  logic [N_CH-1:0]       de_in,
  input  logic [N_CH-1:0]       h_sync_in,
  input  logic [N_CH-1:0]       v_sync_in,
  output logic [PIX_W-1:0]      pixel_out,
  output logic                  de_out,
  output logic                  h_sync_out,
  output logic                  v_sync_out
);

  logic [PIX_W-1:0] pixel_d, pixel_q;
  logic             de_d, de_q, hs_d, hs_q, vs_d, vs_q;

  always_comb begin
    pixel_d = '0;
    de_d    = 1'b0;
    hs_d    = 1'b0;
    vs_d    = 1'b0;
    for (int k = 0; k < N_CH; k++) begin
      if (idx == SEL_W'(k)) begin
        pixel_d = pixel_in[pix_lsb(k, PIX_W) +: PIX_W];
        de_d    = de_in[k];
        hs_d    = h_sync_in[k];
        vs_d    = v_sync_in[k];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pixel_q <= '0;
      de_q    <= 1'b0;
      hs_q    <= 1'b0;
      vs_q    <= 1'b0;
    end else begin
      pixel_q <= pixel_d;
      de_q    <= de_d;
      hs_q    <= hs_d;
      vs_q    <= vs_d;
    end
  end

  assign pixel_out  = pixel_q;
  assign de_out     = de_q;
  assign h_sync_out = hs_q;
  assign v_sync_out = vs_q;

endmodule

// File: rtl/vstream_switch.sv
// Frame-aligned video stream selector: switches channels on the target's
// v_sync leading edge, or forcibly after TIMEOUT cycles without one.
module vstream_switch
  import vs_pkg::*;
#(
  parameter int   N_CH      = 16,
  parameter int   PIX_W     = 24,
  parameter int   SEL_W     = 4,
  parameter logic VS_ACTIVE = 1'b1,
  parameter int   TIMEOUT   = 1000000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [SEL_W-1:0]      select,
  input  logic [N_CH*PIX_W-1:0] pixel_in,
  input  logic [N_CH-1:0]       de_in,
  input  logic [N_CH-1:0]       h_sync_in,
  input  logic [N_CH-1:0]       v_sync_in,
  output logic [PIX_W-1:0]      pixel_out,
  output logic                  de_out,
  output logic                  h_sync_out,
  output logic                  v_sync_out,
  output logic [SEL_W-1:0]      active_sel,
  output logic                  pending,
  output logic                  switch_done,
  output logic                  switch_timeout
);

  localparam int CNT_W = cnt_width(TIMEOUT);
  localparam int SEL_N = 1 << SEL_W;

  state_e           state_q, state_d;
  logic [SEL_W-1:0] target_q, target_d, active_q, active_d, mux_idx;
  logic             vs_prev_q, vs_prev_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [SEL_N-1:0] vs_ext;
  logic             sel_ok, frame_start, done, tmo;

  // Widened so any select/target value indexes without a range check.
  assign vs_ext      = SEL_N'(v_sync_in);
  assign sel_ok      = ({1'b0, select} < (SEL_W+1)'(N_CH));
  assign frame_start = (vs_ext[target_q] == VS_ACTIVE) && (vs_prev_q != VS_ACTIVE);

  always_comb begin
    state_d   = state_q;
    target_d  = target_q;
    vs_prev_d = vs_prev_q;
    cnt_d     = cnt_q;
    active_d  = active_q;
    mux_idx   = active_q;
    done      = 1'b0;
    tmo       = 1'b0;
    case (state_q)
      RUN: begin
        if (sel_ok && select != active_q) begin
          target_d  = select;
          vs_prev_d = vs_ext[select];
          cnt_d     = '0;
          state_d   = WAIT;
        end
      end
      WAIT: begin
        if (select == active_q) begin
          state_d = RUN;
        end else if (sel_ok && select != target_q) begin
          target_d  = select;
          vs_prev_d = vs_ext[select];
          cnt_d     = '0;
        end else if (frame_start) begin
          active_d = target_q;
          mux_idx  = target_q;
          done     = 1'b1;
          state_d  = RUN;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          active_d = target_q;
          mux_idx  = target_q;
          tmo      = 1'b1;
          state_d  = RUN;
        end else begin
          cnt_d     = cnt_q + 1'b1;
          vs_prev_d = vs_ext[target_q];
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= RUN;
      target_q  <= '0;
      vs_prev_q <= 1'b0;
      cnt_q     <= '0;
      active_q  <= '0;
    end else begin
      state_q   <= state_d;
      target_q  <= target_d;
      vs_prev_q <= vs_prev_d;
      cnt_q     <= cnt_d;
      active_q  <= active_d;
    end
  end

  vstream_mux_reg #(.N_CH(N_CH), .PIX_W(PIX_W), .SEL_W(SEL_W)) u_mux (
    .clk        (clk),
    .rst        (rst),
    .idx        (mux_idx),
    .pixel_in   (pixel_in),
    .de_in      (de_in),
    .h_sync_in  (h_sync_in),
    .v_sync_in  (v_sync_in),
    .pixel_out  (pixel_out),
    .de_out     (de_out),
    .h_sync_out (h_sync_out),
    .v_sync_out (v_sync_out)
  );

  assign active_sel     = active_q;
  assign pending        = (state_q == WAIT);
  assign switch_done    = done;
  assign switch_timeout = tmo;

endmodule

// File: tb/tb_vstream_switch.sv
// Directed scenarios plus a randomized run against a cycle-level reference model.
module tb_vstream_switch;

  localparam int N_CH = 4, PIX_W = 8, SEL_W = 3, TMO = 8;

  logic                  clk = 1'b0, rst = 1'b1;
  logic [SEL_W-1:0]      select = '0;
  logic [N_CH*PIX_W-1:0] pixel_in;
  logic [N_CH-1:0]       de = '0, hs = '0, vs = '0;
  logic [PIX_W-1:0]      pixel_out;
  logic                  de_out, h_sync_out, v_sync_out, pending, switch_done, switch_timeout;
  logic [SEL_W-1:0]      active_sel;

  int n_tests = 0, n_fail = 0;

  always #5 clk = ~clk;

  initial for (int k = 0; k < N_CH; k++) pixel_in[k*PIX_W +: PIX_W] = 8'(8'h10 * k);

  vstream_switch #(.N_CH(N_CH), .PIX_W(PIX_W), .SEL_W(SEL_W), .VS_ACTIVE(1'b1), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .select(select), .pixel_in(pixel_in), .de_in(de), .h_sync_in(hs),
    .v_sync_in(vs), .pixel_out(pixel_out), .de_out(de_out), .h_sync_out(h_sync_out),
    .v_sync_out(v_sync_out), .active_sel(active_sel), .pending(pending),
    .switch_done(switch_done), .switch_timeout(switch_timeout)
  );

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; select = '0; vs = '0; hs = '0; de = 4'b0001;
    repeat (3) tick();
    n_tests++;
    if ({pixel_out, de_out, h_sync_out, v_sync_out, active_sel, pending, switch_done, switch_timeout} !== '0) begin
      n_fail++; $display("FAIL reset_outputs got pix=%0h de=%0b act=%0d pend=%0b exp all 0", pixel_out, de_out, active_sel, pending);
    end
    rst = 1'b0;
    tick();
    n_tests++;
    if (pixel_out !== 8'h00 || de_out !== 1'b1 || pending !== 1'b0) begin
      n_fail++; $display("FAIL reset_release got pix=%0h de=%0b pend=%0b exp 00 1 0", pixel_out, de_out, pending);
    end
    de = '0;
  endtask

  task automatic test_retarget_cancel();
    select = 3'd1; vs = '0;
    tick(); tick(); tick();           // WAIT cycles with cnt 0,1 passed; now cnt==2
    select = 3'd2; vs[1] = 1'b1; #1;
    n_tests++;
    if (switch_done !== 1'b0 || pending !== 1'b1) begin
      n_fail++; $display("FAIL retarget_edge got done=%0b pend=%0b exp 0 1", switch_done, pending);
    end
    tick(); vs[1] = 1'b0;
    // seven more WAIT cycles (cnt 0..6) must not time out if cnt restarted
    for (int i = 0; i < 7; i++) begin
      n_tests++;
      if (switch_timeout !== 1'b0 || switch_done !== 1'b0 || pending !== 1'b1 || pixel_out !== 8'h00) begin
        n_fail++; $display("FAIL retarget_hold[%0d] got tmo=%0b done=%0b pend=%0b pix=%0h exp 0 0 1 00", i, switch_timeout, switch_done, pending, pixel_out);
      end
      tick();
    end
    select = 3'd0; #1;
    n_tests++;
    if (switch_timeout !== 1'b0 || switch_done !== 1'b0) begin
      n_fail++; $display("FAIL cancel_pulse got tmo=%0b done=%0b exp 0 0", switch_timeout, switch_done);
    end
    tick();
    n_tests++;
    if (pending !== 1'b0 || active_sel !== 3'd0 || pixel_out !== 8'h00) begin
      n_fail++; $display("FAIL cancel_state got pend=%0b act=%0d pix=%0h exp 0 0 00", pending, active_sel, pixel_out);
    end
  endtask

  task automatic test_aligned();
    select = 3'd2; vs = '0; #1;
    n_tests++;
    if (pending !== 1'b0) begin n_fail++; $display("FAIL aligned_pre got pend=%0b exp 0", pending); end
    tick();
    for (int i = 0; i < 3; i++) begin
      n_tests++;
      if (pending !== 1'b1 || switch_done !== 1'b0) begin
        n_fail++; $display("FAIL aligned_wait[%0d] got pend=%0b done=%0b exp 1 0", i, pending, switch_done);
      end
      tick();
    end
    vs[2] = 1'b1; #1;
    n_tests++;
    if (pending !== 1'b1 || switch_done !== 1'b1 || switch_timeout !== 1'b0) begin
      n_fail++; $display("FAIL aligned_fire got pend=%0b done=%0b tmo=%0b exp 1 1 0", pending, switch_done, switch_timeout);
    end
    tick();
    n_tests++;
    if (pixel_out !== 8'h20 || v_sync_out !== 1'b1 || pending !== 1'b0 || active_sel !== 3'd2 || switch_done !== 1'b0) begin
      n_fail++; $display("FAIL aligned_after got pix=%0h vs=%0b pend=%0b act=%0d exp 20 1 0 2", pixel_out, v_sync_out, pending, active_sel);
    end
  endtask

  task automatic test_timeout();
    select = 3'd3; vs[3] = 1'b0;
    tick();
    for (int i = 0; i < TMO; i++) begin
      n_tests++;
      if (pending !== 1'b1 || switch_timeout !== (i == TMO - 1) || switch_done !== 1'b0 || pixel_out !== 8'h20) begin
        n_fail++; $display("FAIL timeout_cycle[%0d] got pend=%0b tmo=%0b done=%0b pix=%0h exp 1 %0b 0 20", i, pending, switch_timeout, switch_done, pixel_out, i == TMO - 1);
      end
      tick();
    end
    n_tests++;
    if (active_sel !== 3'd3 || pixel_out !== 8'h30 || pending !== 1'b0 || switch_timeout !== 1'b0) begin
      n_fail++; $display("FAIL timeout_after got act=%0d pix=%0h pend=%0b exp 3 30 0", active_sel, pixel_out, pending);
    end
  endtask

  task automatic test_coincide_illegal();
    vs = '0; select = 3'd2;
    tick();
    repeat (TMO - 1) tick();
    vs[2] = 1'b1; #1;
    n_tests++;
    if (switch_done !== 1'b1 || switch_timeout !== 1'b0) begin
      n_fail++; $display("FAIL coincide got done=%0b tmo=%0b exp 1 0", switch_done, switch_timeout);
    end
    tick();
    n_tests++;
    if (active_sel !== 3'd2 || pixel_out !== 8'h20 || pending !== 1'b0) begin
      n_fail++; $display("FAIL coincide_after got act=%0d pix=%0h pend=%0b exp 2 20 0", active_sel, pixel_out, pending);
    end
    select = 3'd5;
    repeat (2) tick();
    n_tests++;
    if (pending !== 1'b0 || active_sel !== 3'd2 || pixel_out !== 8'h20) begin
      n_fail++; $display("FAIL illegal_sel got pend=%0b act=%0d pix=%0h exp 0 2 20", pending, active_sel, pixel_out);
    end
  endtask

  task automatic test_reset_mid_wait();
    vs = '0; select = 3'd1;
    tick(); tick();
    #2 rst = 1'b1; #1;
    n_tests++;
    if (pending !== 1'b0 || active_sel !== 3'd0 || pixel_out !== 8'h00 || v_sync_out !== 1'b0) begin
      n_fail++; $display("FAIL reset_async got pend=%0b act=%0d pix=%0h exp 0 0 00", pending, active_sel, pixel_out);
    end
    select = 3'd0;
    tick(); tick();
    rst = 1'b0;
    tick();
    n_tests++;
    if (pixel_out !== 8'h00 || pending !== 1'b0 || active_sel !== 3'd0) begin
      n_fail++; $display("FAIL reset_mid_release got pix=%0h pend=%0b act=%0d exp 00 0 0", pixel_out, pending, active_sel);
    end
  endtask

  task automatic test_random();
    bit m_wait = 0, m_prev = 0, m_de = 0, m_hs = 0, m_vs = 0;
    int m_active = 0, m_target = 0, m_cnt = 0, m_pix = 0;
    rst = 1'b1; select = '0; vs = '0; de = '0; hs = '0;
    tick(); tick();
    rst = 1'b0;
    for (int c = 0; c < 600; c++) begin
      bit o_wait, e_done, e_tmo;
      int o_active, sel, src;
      if ($urandom_range(0, 9) == 0) select = 3'($urandom_range(0, 7));
      for (int k = 0; k < N_CH; k++) if ($urandom_range(0, 5) == 0) vs[k] = ~vs[k];
      de = 4'($urandom); hs = 4'($urandom);
      #1;
      o_wait = m_wait; o_active = m_active; sel = int'(select);
      e_done = 0; e_tmo = 0; src = m_active;
      if (!m_wait) begin
        if (sel < N_CH && sel != m_active) begin
          m_wait = 1; m_target = sel; m_prev = vs[sel]; m_cnt = 0;
        end
      end else if (sel == m_active) begin
        m_wait = 0;
      end else if (sel < N_CH && sel != m_target) begin
        m_target = sel; m_prev = vs[sel]; m_cnt = 0;
      end else if (vs[m_target] && !m_prev) begin
        e_done = 1; src = m_target; m_active = m_target; m_wait = 0;
      end else if (m_cnt == TMO - 1) begin
        e_tmo = 1; src = m_target; m_active = m_target; m_wait = 0;
      end else begin
        m_cnt++; m_prev = vs[m_target];
      end
      n_tests++;
      if (pending !== o_wait || switch_done !== e_done || switch_timeout !== e_tmo || int'(active_sel) != o_active) begin
        n_fail++; $display("FAIL rand_ctrl[%0d] got pend=%0b done=%0b tmo=%0b act=%0d exp %0b %0b %0b %0d", c, pending, switch_done, switch_timeout, active_sel, o_wait, e_done, e_tmo, o_active);
      end
      n_tests++;
      if (int'(pixel_out) != m_pix || de_out !== m_de || h_sync_out !== m_hs || v_sync_out !== m_vs) begin
        n_fail++; $display("FAIL rand_data[%0d] got pix=%0h de=%0b hs=%0b vs=%0b exp %0h %0b %0b %0b", c, pixel_out, de_out, h_sync_out, v_sync_out, m_pix, m_de, m_hs, m_vs);
      end
      m_pix = 16 * src; m_de = de[src]; m_hs = hs[src]; m_vs = vs[src];
      tick();
    end
  endtask

  initial begin
    #1;
    test_reset();
    test_retarget_cancel();
    test_aligned();
    test_timeout();
    test_coincide_illegal();
    test_reset_mid_wait();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/vstream_switch.md
Name: vstream_switch

Overview:
- Parametrised successor to the fixed 16-way output mux of the vision pipeline top level.
- Selects one of N_CH video streams (pixel/de/h_sync/v_sync) and forwards it through one output register stage.
- Switches only on a frame boundary of the target stream, so the display never sees a torn frame.
- If the target stream never produces a frame start, the switch is forced after a timeout. Channel-switch status is reported to the control logic.

Parameters:
N_CH, 16, number of input streams (2..64)
PIX_W, 24, pixel width per stream
SEL_W, 4, select width; 2**SEL_W >= N_CH
VS_ACTIVE, 1, v_sync active level; frame start = transition to this level
TIMEOUT, 1000000, cycles to wait for target frame start before forcing the switch (>=2)

Ports:
clk  in  1  pixel clock
rst  in  1  asynchronous, active-high reset
select  in  SEL_W  requested channel; values >= N_CH are ignored
pixel_in  in  N_CH*PIX_W  channel k at bits [k*PIX_W +: PIX_W]
de_in  in  N_CH  data enable, bit k = channel k
h_sync_in  in  N_CH  horizontal sync, bit k = channel k
v_sync_in  in  N_CH  vertical sync, bit k = channel k
pixel_out  out  PIX_W  registered selected pixel
de_out  out  1  registered selected de
h_sync_out  out  1  registered selected h_sync
v_sync_out  out  1  registered selected v_sync
active_sel  out  SEL_W  channel currently forwarded
pending  out  1  high while in WAIT
switch_done  out  1  1-cycle pulse on a frame-aligned switch
switch_timeout  out  1  1-cycle pulse on a forced switch

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-high (rst).
- Reset values: all outputs 0; active_sel=0; state=RUN; target=0; vs_prev=0; cnt=0.
- Output path:
  - Every cycle, the out registers load channel mux_idx; latency is 1 cycle.
  - mux_idx = target when (state==WAIT and a switch fires this cycle), else active_sel.
  - The first forwarded cycle of the new channel is therefore its frame-start cycle.
- FSM RUN:
  - If select < N_CH and select != active_sel: target<=select; vs_prev<=v_sync_in[select]; cnt<=0; go to WAIT.
  - Otherwise stay in RUN.
- FSM WAIT (priority order):
  - 1. select == active_sel: cancel. Go to RUN, no pulse.
  - 2. select < N_CH and select != target: retarget. target<=select; vs_prev<=v_sync_in[select]; cnt<=0; stay in WAIT. Any edge on the old target in this cycle is ignored.
  - 3. Frame start (v_sync_in[target]==VS_ACTIVE and vs_prev!=VS_ACTIVE): active_sel<=target; switch_done=1; go to RUN.
  - 4. cnt == TIMEOUT-1: active_sel<=target; switch_timeout=1; go to RUN. This switch is mid-frame by design.
  - 5. Otherwise: cnt<=cnt+1; vs_prev<=v_sync_in[target].
- Counter and pulses:
  - cnt width = $clog2(TIMEOUT); it never wraps, because the timeout fires first.
  - If frame start and timeout coincide, frame start wins: switch_done only.
  - switch_done and switch_timeout are never high together.
- Status outputs: pending = (state==WAIT), combinational from the state register. active_sel is a register.
- Out-of-range select:
  - In RUN it is ignored.
  - In WAIT it neither cancels nor retargets; the pending switch continues.
- Select held through a switch: no re-trigger, because select == active_sel afterwards.
- Reset asserted mid-WAIT: immediate return to reset values; output goes to channel 0 one cycle after release.
- The select input is assumed synchronous to clk. No CDC is performed inside this block.

Decomposition:
- Shared package (vs_pkg): stream-bus slice helper constants, state encoding (RUN=1'b0, WAIT=1'b1), and $clog2-based width localparams.
- One sub-module, vstream_mux_reg: parametrised N_CH:1 combinational mux plus the output register with async reset. The top level holds the FSM, edge detector and timeout counter.

Test Plan:
All scenarios use N_CH=4, PIX_W=8, TIMEOUT=8, and channel k driving a constant pixel 8'h10*k.
- Reset-to-run: rst held 3 cycles, then released, select=0 -> outputs 0 during reset; pixel_out=8'h00 from cycle 1; pending=0.
- Aligned switch: select=2 while v_sync_in[2]=0; raise v_sync_in[2] at cycle t -> pending=1 until t; switch_done pulses at t; pixel_out=8'h20 and v_sync_out=1 at t+1.
- Timeout: select=3 with v_sync_in[3] held at 0 -> switch_timeout pulses exactly 8 cycles after pending rises; active_sel=3; pixel_out=8'h30 next cycle.
- Retarget and cancel: select 0->1, then ->2 after 3 cycles, with an edge on ch1 in that cycle -> no switch and cnt restarts; then select->0 -> pending falls, no pulses, pixel_out stays 8'h00.
- Coincidence and illegal select: ch2 edge exactly on cycle cnt==7 -> only switch_done. Then select=5 (>=N_CH) -> no pending, active_sel unchanged.
- Reset mid-WAIT: assert rst while pending=1 -> pending=0, active_sel=0, outputs 0 immediately (asynchronous).
